// File: rtl/gt_usplus_qpll_reset_seq_pkg.sv
// Shared types and constants for the per-quad QPLL reset/lock sequencer.
package gt_usplus_qpll_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } qpll_seq_state_e;

  localparam int unsigned RETRY_W      = 2;
  localparam int unsigned N_COMMON_MAX = 4;

endpackage

// File: rtl/gt_usplus_qpll_chan_seq.sv
// One quad: lock synchroniser, reset/timeout/filter counters and sequencing FSM.
module gt_usplus_qpll_chan_seq
  import gt_usplus_qpll_reset_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 32,
  parameter int unsigned LOCK_FILTER  = 8,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               qpll_lock,
  output logic               qpll_reset,
  output logic               quad_locked,
  output logic               lock_fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT + 1);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
  logic lock_s;

  qpll_seq_state_e     state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d, retry_sat;
  logic [RETRY_W:0]    retry_inc;
  logic                fail_q, fail_d;
  logic                qpll_reset_q, qpll_reset_d;
  logic                quad_locked_q, quad_locked_d;
  logic                to_done, filt_done, timeout, retry_exhausted;

  assign lock_s = sync_q[1];

  // State, counters and output decodes all registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      state_q       <= ST_RESET;
      rst_cnt_q     <= '0;
      filt_cnt_q    <= '0;
      to_cnt_q      <= '0;
      retry_q       <= '0;
      fail_q        <= 1'b0;
      qpll_reset_q  <= 1'b1;
      quad_locked_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], qpll_lock};
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      filt_cnt_q    <= filt_cnt_d;
      to_cnt_q      <= to_cnt_d;
      retry_q       <= retry_d;
      fail_q        <= fail_d;
      qpll_reset_q  <= qpll_reset_d;
      quad_locked_q <= quad_locked_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    filt_cnt_d      = filt_cnt_q;
    to_cnt_d        = to_cnt_q;
    retry_d         = retry_q;
    fail_d          = fail_q;
    timeout         = 1'b0;
    to_done         = (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1));
    filt_done       = lock_s && (filt_cnt_q == FILT_W'(LOCK_FILTER - 1));
    retry_inc       = {1'b0, retry_q} + (RETRY_W + 1)'(1);
    retry_sat       = retry_inc[RETRY_W] ? '1 : retry_inc[RETRY_W-1:0];
    retry_exhausted = (32'(retry_inc) > MAX_RETRY);

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (to_done) begin
          timeout = 1'b1;
        end else if (lock_s) begin
          state_d    = ST_FILTER;
          filt_cnt_d = '0;
        end
      end
      // Filter completion beats a coincident timeout.
      ST_FILTER: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (filt_done) begin
          state_d = ST_LOCKED;
        end else if (to_done) begin
          timeout = 1'b1;
        end else if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          filt_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!lock_s) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d   = ST_RESET;
        rst_cnt_d = '0;
      end
    endcase

    if (timeout) begin
      retry_d   = retry_sat;
      rst_cnt_d = '0;
      if (retry_exhausted) begin
        state_d = ST_FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = ST_RESET;
      end
    end

    if (start) begin
      state_d    = ST_RESET;
      rst_cnt_d  = '0;
      filt_cnt_d = '0;
      to_cnt_d   = '0;
      retry_d    = '0;
      fail_d     = 1'b0;
    end

    qpll_reset_d  = (state_d == ST_RESET) || (state_d == ST_FAIL);
    quad_locked_d = (state_d == ST_LOCKED);
  end

  assign qpll_reset  = qpll_reset_q;
  assign quad_locked = quad_locked_q;
  assign lock_fail   = fail_q;
  assign retry_cnt   = retry_q;

endmodule

// File: rtl/gt_usplus_qpll_reset_seq.sv
// Top: one sequencer per QPLL quad plus the registered all_locked gate.
module gt_usplus_qpll_reset_seq
  import gt_usplus_qpll_reset_seq_pkg::*;
#(
  parameter int unsigned N_COMMON     = 2,
  parameter int unsigned RESET_CYCLES = 32,
  parameter int unsigned LOCK_FILTER  = 8,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_COMMON-1:0]           qpll_lock,
  output logic [N_COMMON-1:0]           qpll_reset,
  output logic [N_COMMON-1:0]           quad_locked,
  output logic [N_COMMON-1:0]           lock_fail,
  output logic                          all_locked,
  output logic [N_COMMON*RETRY_W-1:0]   retry_cnt
);

  if (N_COMMON < 1 || N_COMMON > N_COMMON_MAX) begin : g_bad_n_common
    $error("gt_usplus_qpll_reset_seq: N_COMMON must be 1..4");
  end

  logic all_locked_q;

  for (genvar i = 0; i < N_COMMON; i++) begin : g_quad
    gt_usplus_qpll_chan_seq #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_FILTER  (LOCK_FILTER),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .MAX_RETRY    (MAX_RETRY)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .qpll_lock   (qpll_lock[i]),
      .qpll_reset  (qpll_reset[i]),
      .quad_locked (quad_locked[i]),
      .lock_fail   (lock_fail[i]),
      .retry_cnt   (retry_cnt[i*RETRY_W +: RETRY_W])
    );
  end

  // One cycle behind quad_locked so downstream resets see a clean gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &quad_locked;
    end
  end

  assign all_locked = all_locked_q;

endmodule

// File: tb/tb_gt_usplus_qpll_reset_seq.sv
// Directed bench for the QPLL reset/lock sequencer (RESET=4, FILTER=3, TIMEOUT=20, RETRY=2).
module tb_gt_usplus_qpll_reset_seq;

  localparam int unsigned N_COMMON     = 2;
  localparam int unsigned RESET_CYCLES = 4;
  localparam int unsigned LOCK_FILTER  = 3;
  localparam int unsigned LOCK_TIMEOUT = 20;
  localparam int unsigned MAX_RETRY    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] qpll_lock;
  logic [1:0] qpll_reset;
  logic [1:0] quad_locked;
  logic [1:0] lock_fail;
  logic       all_locked;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gt_usplus_qpll_reset_seq #(
    .N_COMMON     (N_COMMON),
    .RESET_CYCLES (RESET_CYCLES),
    .LOCK_FILTER  (LOCK_FILTER),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .qpll_lock   (qpll_lock),
    .qpll_reset  (qpll_reset),
    .quad_locked (quad_locked),
    .lock_fail   (lock_fail),
    .all_locked  (all_locked),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Position 0 after return is the first cycle with rst low.
  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    qpll_lock = 2'b00;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    qpll_lock = 2'b11;
    step();
    step();
    n_checks++;
    if (qpll_reset !== 2'b11) begin
      n_fail++; $display("FAIL reset.qpll_reset: got %b want 11", qpll_reset);
    end
    n_checks++;
    if (quad_locked !== 2'b00) begin
      n_fail++; $display("FAIL reset.quad_locked: got %b want 00", quad_locked);
    end
    n_checks++;
    if (lock_fail !== 2'b00) begin
      n_fail++; $display("FAIL reset.lock_fail: got %b want 00", lock_fail);
    end
    n_checks++;
    if (all_locked !== 1'b0) begin
      n_fail++; $display("FAIL reset.all_locked: got %b want 0", all_locked);
    end
    n_checks++;
    if (retry_cnt !== 4'h0) begin
      n_fail++; $display("FAIL reset.retry_cnt: got %h want 0", retry_cnt);
    end
    qpll_lock = 2'b00;
  endtask

  task automatic test_nominal();
    logic [1:0] e_qr, e_ql;
    logic       e_al;
    do_reset();
    for (int k = 0; k <= 13; k++) begin
      e_qr = (k < 4) ? 2'b11 : 2'b00;
      e_ql = (k >= 11) ? 2'b11 : 2'b00;
      e_al = (k >= 12);
      n_checks++;
      if (qpll_reset !== e_qr) begin
        n_fail++; $display("FAIL nominal.qpll_reset k=%0d: got %b want %b", k, qpll_reset, e_qr);
      end
      n_checks++;
      if (quad_locked !== e_ql) begin
        n_fail++; $display("FAIL nominal.quad_locked k=%0d: got %b want %b", k, quad_locked, e_ql);
      end
      n_checks++;
      if (all_locked !== e_al) begin
        n_fail++; $display("FAIL nominal.all_locked k=%0d: got %b want %b", k, all_locked, e_al);
      end
      if (k == 5) qpll_lock = 2'b11;
      step();
    end
  endtask

  task automatic test_glitch();
    logic [1:0] e_ql;
    do_reset();
    for (int k = 0; k <= 15; k++) begin
      e_ql = (k >= 14) ? 2'b11 : 2'b00;
      n_checks++;
      if (quad_locked !== e_ql) begin
        n_fail++; $display("FAIL glitch.quad_locked k=%0d: got %b want %b", k, quad_locked, e_ql);
      end
      if (k == 5) qpll_lock = 2'b11;
      if (k == 7) qpll_lock = 2'b00;
      if (k == 8) qpll_lock = 2'b11;
      step();
    end
    n_checks++;
    if (retry_cnt !== 4'h0) begin
      n_fail++; $display("FAIL glitch.retry_cnt: got %h want 0", retry_cnt);
    end
  endtask

  task automatic test_retry_exhaustion();
    logic [1:0] e_qr, e_lf, r;
    logic [3:0] e_rc;
    do_reset();
    for (int k = 0; k <= 86; k++) begin
      if (k <= 80) begin
        e_qr = (k < 4 || (k >= 24 && k < 28) || (k >= 48 && k < 52) || k >= 72) ? 2'b11 : 2'b00;
        r    = (k < 24) ? 2'd0 : (k < 48) ? 2'd1 : (k < 72) ? 2'd2 : 2'd3;
        e_lf = (k >= 72) ? 2'b11 : 2'b00;
      end else begin
        e_qr = (k < 85) ? 2'b11 : 2'b00;
        r    = 2'd0;
        e_lf = 2'b00;
      end
      e_rc = {r, r};
      n_checks++;
      if (qpll_reset !== e_qr) begin
        n_fail++; $display("FAIL retry.qpll_reset k=%0d: got %b want %b", k, qpll_reset, e_qr);
      end
      n_checks++;
      if (retry_cnt !== e_rc) begin
        n_fail++; $display("FAIL retry.retry_cnt k=%0d: got %h want %h", k, retry_cnt, e_rc);
      end
      n_checks++;
      if (lock_fail !== e_lf) begin
        n_fail++; $display("FAIL retry.lock_fail k=%0d: got %b want %b", k, lock_fail, e_lf);
      end
      if (k == 80) start = 1'b1;
      if (k == 81) start = 1'b0;
      step();
    end
  endtask

  task automatic test_loss_of_lock();
    logic [1:0] e_qr, e_ql;
    logic       e_al;
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      e_ql = (k < 8) ? 2'b00 : (k < 15) ? 2'b11 : (k < 23) ? 2'b01 : 2'b11;
      e_al = (k >= 9 && k < 16) || (k >= 24);
      e_qr = (k < 4) ? 2'b11 : (k >= 15 && k < 19) ? 2'b10 : 2'b00;
      n_checks++;
      if (quad_locked !== e_ql) begin
        n_fail++; $display("FAIL loss.quad_locked k=%0d: got %b want %b", k, quad_locked, e_ql);
      end
      n_checks++;
      if (all_locked !== e_al) begin
        n_fail++; $display("FAIL loss.all_locked k=%0d: got %b want %b", k, all_locked, e_al);
      end
      n_checks++;
      if (qpll_reset !== e_qr) begin
        n_fail++; $display("FAIL loss.qpll_reset k=%0d: got %b want %b", k, qpll_reset, e_qr);
      end
      if (k == 0)  qpll_lock = 2'b11;
      if (k == 12) qpll_lock = 2'b01;
      if (k == 16) qpll_lock = 2'b11;
      step();
    end
    n_checks++;
    if (retry_cnt !== 4'h0) begin
      n_fail++; $display("FAIL loss.retry_cnt: got %h want 0", retry_cnt);
    end
  endtask

  task automatic test_start_mid();
    logic [1:0] e_qr;
    logic [3:0] e_rc;
    do_reset();
    for (int k = 0; k <= 38; k++) begin
      if (k <= 30) begin
        e_qr = (k < 4 || (k >= 24 && k < 28)) ? 2'b11 : 2'b00;
        e_rc = (k < 24) ? 4'h0 : 4'h5;
      end else begin
        e_qr = (k < 37) ? 2'b11 : 2'b00;
        e_rc = 4'h0;
      end
      n_checks++;
      if (qpll_reset !== e_qr) begin
        n_fail++; $display("FAIL start.qpll_reset k=%0d: got %b want %b", k, qpll_reset, e_qr);
      end
      n_checks++;
      if (retry_cnt !== e_rc) begin
        n_fail++; $display("FAIL start.retry_cnt k=%0d: got %h want %h", k, retry_cnt, e_rc);
      end
      if (k == 30) start = 1'b1;
      if (k == 31) start = 1'b0;
      if (k == 32) start = 1'b1;
      if (k == 33) start = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] e_qr, e_ql;
    logic       e_al;
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      e_ql = (k >= 8 && k <= 10) ? 2'b11 : 2'b00;
      e_al = (k == 9 || k == 10);
      e_qr = (k < 4 || k == 11) ? 2'b11 : 2'b00;
      n_checks++;
      if (quad_locked !== e_ql) begin
        n_fail++; $display("FAIL rstmid.quad_locked k=%0d: got %b want %b", k, quad_locked, e_ql);
      end
      n_checks++;
      if (all_locked !== e_al) begin
        n_fail++; $display("FAIL rstmid.all_locked k=%0d: got %b want %b", k, all_locked, e_al);
      end
      n_checks++;
      if (qpll_reset !== e_qr) begin
        n_fail++; $display("FAIL rstmid.qpll_reset k=%0d: got %b want %b", k, qpll_reset, e_qr);
      end
      if (k == 0)  qpll_lock = 2'b11;
      if (k == 10) rst = 1'b1;
      if (k < 11) step();
    end
    n_checks++;
    if (lock_fail !== 2'b00 || retry_cnt !== 4'h0) begin
      n_fail++; $display("FAIL rstmid.fail_retry: got %b/%h want 00/0", lock_fail, retry_cnt);
    end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    qpll_lock = 2'b00;
    test_reset();
    test_nominal();
    test_glitch();
    test_retry_exhaustion();
    test_loss_of_lock();
    test_start_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
